// File: rtl/freq_meter.sv
// freq_meter: counts CLK cycles per DIV_IN period, flags overflow, match and lock.
// Define FREQ_METER_AVG_EN to publish the mean of every 4 measurements.
module freq_meter #(
  parameter int WIDTH  = 16,
  parameter int LOCK_N = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             enable,
  input  logic             DIV_IN,
  input  logic [WIDTH-1:0] EXP,
  output logic [WIDTH-1:0] PERIOD,
  output logic             VALID,
  output logic             OVF,
  output logic             MATCH,
  output logic             LOCK
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]       RUN_MAX = 4'(LOCK_N);

  logic             r_sync1, r_sync2, r_sync3;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic [3:0]       r_run;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_ovf_o;
  logic             r_match;

  logic             w_rise;
  logic             w_meas;
  logic             w_meas_ovf;
  logic             w_pub;
  logic [WIDTH-1:0] w_pub_val;
  logic             w_pub_ovf;
  logic [3:0]       w_run_nx;

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_meas = enable && (r_state == S_COUNT) && w_rise;
  // A count sitting at the ceiling on the closing edge is saturated too.
  assign w_meas_ovf = r_ovf | (r_cnt == CNT_MAX);

`ifdef FREQ_METER_AVG_EN
  logic [1:0]       r_sub;
  logic [WIDTH+1:0] r_acc;
  logic             r_aovf;
  logic [WIDTH+1:0] w_acc_sum;

  assign w_acc_sum = r_acc + {2'b00, r_cnt};
  assign w_pub     = w_meas && (r_sub == 2'd3);
  assign w_pub_val = WIDTH'(w_acc_sum >> 2);
  assign w_pub_ovf = r_aovf | w_meas_ovf;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sub  <= '0;
      r_acc  <= '0;
      r_aovf <= 1'b0;
    end else if (!enable || (r_state != S_COUNT)) begin
      r_sub  <= '0;
      r_acc  <= '0;
      r_aovf <= 1'b0;
    end else if (w_meas) begin
      if (r_sub == 2'd3) begin
        r_sub  <= '0;
        r_acc  <= '0;
        r_aovf <= 1'b0;
      end else begin
        r_sub  <= r_sub + 2'd1;
        r_acc  <= w_acc_sum;
        r_aovf <= w_pub_ovf;
      end
    end
  end
`else
  assign w_pub     = w_meas;
  assign w_pub_val = r_cnt;
  assign w_pub_ovf = w_meas_ovf;
`endif

  always_comb begin
    w_run_nx = 4'd1;
    if (w_pub_ovf) begin
      w_run_nx = 4'd0;
    end else if ((w_pub_val == r_period) && (r_run != 4'd0)) begin
      w_run_nx = (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync3  <= 1'b0;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_run    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_ovf_o  <= 1'b0;
      r_match  <= 1'b0;
    end else begin
      r_sync1 <= DIV_IN;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_valid <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_run   <= '0;
        r_match <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_ARM;
          S_ARM: begin
            if (w_rise) begin
              r_state <= S_COUNT;
              r_cnt   <= {{(WIDTH-1){1'b0}}, 1'b1};
              r_ovf   <= 1'b0;
            end
          end
          S_COUNT: begin
            if (w_rise) begin
              r_cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
              r_ovf <= 1'b0;
              if (w_pub) begin
                r_period <= w_pub_val;
                r_ovf_o  <= w_pub_ovf;
                r_valid  <= 1'b1;
                r_match  <= !w_pub_ovf && (w_pub_val == EXP);
                r_run    <= w_run_nx;
              end
            end else if (r_cnt == CNT_MAX) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign PERIOD = r_period;
  assign VALID  = r_valid;
  assign OVF    = r_ovf_o;
  assign MATCH  = r_match;
  assign LOCK   = (r_run >= RUN_MAX);

endmodule
